plic_port_arbiter: RTL and testbench

- Round-robin arbiter sharing the PLIC's single 22-bit BRAM-style control port among NUM_REQ requesters (e.g. per-hart MMIO bridges, a debug master).
- Registers the winning command onto the PLIC port and routes the 1-cycle-latency read data back to the owning requester.
- Supports short locked sequences (read-modify-write of enable words, claim then complete) without interleaving from other requesters.

---
 rtl/plic_port_arbiter_if.sv | 28 ++
 rtl/plic_port_arbiter.sv | 84 ++++++++
 tb/tb_plic_port_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/plic_port_arbiter_if.sv
// plic_port_arbiter_if: requester command/response bundle plus the shared PLIC BRAM port
interface plic_port_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0][21:0] req_addr;
    logic [NUM_REQ-1:0]       req_we;
    logic [NUM_REQ-1:0][31:0] req_wdata;
    logic [NUM_REQ-1:0]       req_lock;
    logic [NUM_REQ-1:0]       resp_valid;
    logic [31:0]              resp_rdata;
    logic [21:0]              bram_addr;
    logic                     bram_en;
    logic                     bram_we;
    logic [31:0]              bram_wrdata;
    logic [31:0]              bram_rddata;

    modport master (
        output req_valid, req_addr, req_we, req_wdata, req_lock, bram_rddata,
        input  req_ready, resp_valid, resp_rdata, bram_addr, bram_en, bram_we, bram_wrdata
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_wdata, req_lock, bram_rddata,
        output req_ready, resp_valid, resp_rdata, bram_addr, bram_en, bram_we, bram_wrdata
    );
endinterface

// File: rtl/plic_port_arbiter.sv
// plic_port_arbiter: round-robin sharing of the PLIC BRAM port with short locked sequences
module plic_port_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int LOCK_MAX = 2
) (
    input logic              clk,
    input logic              rstn,
    plic_port_arbiter_if.slave bus
);
    localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(LOCK_MAX + 1);

    logic [PW-1:0]      ptr, win, lock_owner, cmd_owner, rsp_owner;
    logic               lock_on, found, rsp_v, lock_keep;
    logic [CW-1:0]      lock_cnt, lock_nxt;
    logic [NUM_REQ-1:0] elig;

    assign elig            = lock_on ? bus.req_valid & (NUM_REQ'(1) << lock_owner) : bus.req_valid;
    assign lock_nxt        = lock_cnt + CW'(1);
    assign lock_keep       = bus.req_lock[win] && lock_nxt != CW'(LOCK_MAX);
    assign bus.req_ready   = found ? NUM_REQ'(1) << win : '0;
    assign bus.resp_valid  = rsp_v ? NUM_REQ'(1) << rsp_owner : '0;
    assign bus.resp_rdata  = bus.bram_rddata;

    // first eligible requester at or after the pointer, wrapping around
    always_comb begin
        int idx;
        win   = '0;
        found = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            idx = idx >= NUM_REQ ? idx - NUM_REQ : idx;
            if (elig[idx]) begin
                win   = PW'(idx);
                found = 1'b1;
            end
        end
    end

    // pointer and lock bookkeeping on every accepted beat
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr        <= '0;
            lock_on    <= 1'b0;
            lock_owner <= '0;
            lock_cnt   <= '0;
        end else if (found) begin
            ptr        <= win == PW'(NUM_REQ - 1) ? '0 : win + PW'(1);
            lock_on    <= lock_keep;
            lock_owner <= win;
            lock_cnt   <= lock_keep ? lock_nxt : '0;
        end
    end

    // command stage: register the winner onto the PLIC port, hold fields when idle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.bram_en     <= 1'b0;
            bus.bram_we     <= 1'b0;
            bus.bram_addr   <= '0;
            bus.bram_wrdata <= '0;
            cmd_owner       <= '0;
        end else begin
            bus.bram_en <= found;
            if (found) begin
                bus.bram_we     <= bus.req_we[win];
                bus.bram_addr   <= bus.req_addr[win];
                bus.bram_wrdata <= bus.req_wdata[win];
                cmd_owner       <= win;
            end
        end
    end

    // response stage: track which requester owns the data the PLIC returns this cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_v     <= 1'b0;
            rsp_owner <= '0;
        end else begin
            rsp_v     <= bus.bram_en;
            rsp_owner <= cmd_owner;
        end
    end
endmodule

// File: tb/tb_plic_port_arbiter.sv
// tb_plic_port_arbiter: grant tables, reset corner case and random traffic against a reference model
module tb_plic_port_arbiter;
    localparam int N  = 2;
    localparam int LM = 2;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    plic_port_arbiter_if #(.NUM_REQ(N)) bus ();

    plic_port_arbiter #(.NUM_REQ(N), .LOCK_MAX(LM)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    function automatic logic [31:0] plic_f(input logic [21:0] a, input logic we, input logic [31:0] d);
        return {10'h2A5, a} ^ (we ? d : 32'h0);
    endfunction

    // PLIC stand-in: data for an access appears the cycle after bram_en
    always @(posedge clk)
        bus.bram_rddata <= bus.bram_en ? plic_f(bus.bram_addr, bus.bram_we, bus.bram_wrdata) : 32'hDEAD_BEEF;

    typedef struct {
        bit          v;
        int          own;
        logic [21:0] addr;
        logic        we;
        logic [31:0] wdata;
    } beat_t;

    int    ptr_m, lock_m, cnt_m;
    beat_t s1, s2;

    typedef struct packed {
        logic [N-1:0] v;
        logic [N-1:0] lk;
        logic [N-1:0] w;
        logic [N-1:0] rdy;
    } vec_t;

    localparam int NV = 23;
    vec_t tbl [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ptr_m  = 0;
        lock_m = -1;
        cnt_m  = 0;
        s1     = '{v: 1'b0, own: 0, addr: 22'h0, we: 1'b0, wdata: 32'h0};
        s2     = s1;
    endtask

    function automatic int model_win(input logic [N-1:0] v);
        if (lock_m >= 0) return v[lock_m] ? lock_m : -1;
        for (int k = 0; k < N; k++)
            if (v[(ptr_m + k) % N]) return (ptr_m + k) % N;
        return -1;
    endfunction

    // one clock: drive, compare against model mid-cycle, then advance the model past the edge
    task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] lk, input logic [N-1:0] w,
                         input bit hand, input logic [N-1:0] exp_rdy);
        int           wn;
        logic [N-1:0] er, ev;
        bus.req_valid = v;
        bus.req_lock  = lk;
        bus.req_we    = w;
        for (int i = 0; i < N; i++) begin
            bus.req_addr[i]  = 22'($urandom);
            bus.req_wdata[i] = $urandom;
        end
        wn = model_win(v);
        er = wn >= 0 ? N'(1) << wn : '0;
        ev = s2.v ? N'(1) << s2.own : '0;
        #3;
        chk("req_ready", 64'(bus.req_ready), 64'(er));
        if (hand) chk("grant_table", 64'(bus.req_ready), 64'(exp_rdy));
        chk("bram_en", 64'(bus.bram_en), 64'(s1.v));
        chk("bram_addr", 64'(bus.bram_addr), 64'(s1.addr));
        chk("bram_we", 64'(bus.bram_we), 64'(s1.we));
        chk("bram_wrdata", 64'(bus.bram_wrdata), 64'(s1.wdata));
        chk("resp_valid", 64'(bus.resp_valid), 64'(ev));
        if (s2.v) chk("resp_rdata", 64'(bus.resp_rdata), 64'(plic_f(s2.addr, s2.we, s2.wdata)));
        @(posedge clk);
        #1;
        s2 = s1;
        if (wn >= 0) begin
            s1 = '{v: 1'b1, own: wn, addr: bus.req_addr[wn], we: bus.req_we[wn], wdata: bus.req_wdata[wn]};
            ptr_m = (wn + 1) % N;
            if (lk[wn]) begin
                cnt_m++;
                lock_m = wn;
                if (cnt_m == LM) begin
                    lock_m = -1;
                    cnt_m  = 0;
                end
            end else begin
                lock_m = -1;
                cnt_m  = 0;
            end
        end else begin
            s1.v = 1'b0;
        end
    endtask

    initial begin
        tbl = '{
            '{2'b01, 2'b00, 2'b00, 2'b01},
            '{2'b00, 2'b00, 2'b00, 2'b00},
            '{2'b00, 2'b00, 2'b00, 2'b00},
            '{2'b10, 2'b00, 2'b00, 2'b10},
            '{2'b11, 2'b00, 2'b00, 2'b01},
            '{2'b11, 2'b00, 2'b00, 2'b10},
            '{2'b11, 2'b00, 2'b00, 2'b01},
            '{2'b11, 2'b00, 2'b00, 2'b10},
            '{2'b11, 2'b00, 2'b00, 2'b01},
            '{2'b11, 2'b00, 2'b00, 2'b10},
            '{2'b00, 2'b00, 2'b00, 2'b00},
            '{2'b00, 2'b00, 2'b00, 2'b00},
            '{2'b11, 2'b01, 2'b00, 2'b01},
            '{2'b10, 2'b00, 2'b00, 2'b00},
            '{2'b11, 2'b00, 2'b01, 2'b01},
            '{2'b10, 2'b00, 2'b00, 2'b10},
            '{2'b00, 2'b00, 2'b00, 2'b00},
            '{2'b11, 2'b01, 2'b00, 2'b01},
            '{2'b11, 2'b01, 2'b00, 2'b01},
            '{2'b11, 2'b01, 2'b00, 2'b10},
            '{2'b11, 2'b01, 2'b00, 2'b01},
            '{2'b11, 2'b00, 2'b00, 2'b01},
            '{2'b00, 2'b00, 2'b00, 2'b00}
        };
        bus.req_valid   = '0;
        bus.req_lock    = '0;
        bus.req_we      = '0;
        bus.req_addr    = '0;
        bus.req_wdata   = '0;
        bus.bram_rddata = '0;
        model_reset();
        #12;
        chk("rst_bram_en", 64'(bus.bram_en), 64'(0));
        chk("rst_bram_addr", 64'(bus.bram_addr), 64'(0));
        chk("rst_bram_wrdata", 64'(bus.bram_wrdata), 64'(0));
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
        chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
        @(posedge clk);
        #1;
        rstn = 1'b1;

        for (int i = 0; i < NV; i++)
            cycle(tbl[i].v, tbl[i].lk, tbl[i].w, 1'b1, tbl[i].rdy);
        repeat (10) cycle(2'b00, 2'b00, 2'b00, 1'b1, 2'b00);
        cycle(2'b11, 2'b00, 2'b00, 1'b1, 2'b10);
        cycle(2'b00, 2'b00, 2'b00, 1'b1, 2'b00);
        cycle(2'b00, 2'b00, 2'b00, 1'b1, 2'b00);

        cycle(2'b01, 2'b00, 2'b00, 1'b1, 2'b01);
        chk("pre_rst_bram_en", 64'(bus.bram_en), 64'(1));
        rstn = 1'b0;
        #1;
        chk("async_bram_en", 64'(bus.bram_en), 64'(0));
        chk("async_resp_valid", 64'(bus.resp_valid), 64'(0));
        @(posedge clk);
        #1;
        chk("held_rst_resp_valid", 64'(bus.resp_valid), 64'(0));
        rstn = 1'b1;
        model_reset();
        repeat (3) cycle(2'b00, 2'b00, 2'b00, 1'b1, 2'b00);
        cycle(2'b11, 2'b00, 2'b00, 1'b1, 2'b01);
        cycle(2'b00, 2'b00, 2'b00, 1'b1, 2'b00);

        repeat (400) cycle(N'($urandom), N'($urandom), N'($urandom), 1'b0, '0);
        repeat (3) cycle(2'b00, 2'b00, 2'b00, 1'b1, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
